// File: rtl/serial_alu.sv
// Digit-serial ALU: processes DIGIT bits per cycle, LSB first, for add/sub/and/or/slt.
// Operation accepted through a start handshake; result returned through a result handshake.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [CW-1:0]      r_count;
    logic               r_carry;

    logic                   w_invert_b;
    logic [DIGIT-1:0]       w_a_dig;
    logic [DIGIT-1:0]       w_b_dig;
    logic [DIGIT:0]         w_sum;
    logic                   w_c_msb;
    logic                   w_ovf;
    logic [DIGIT-1:0]       w_digit;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_shifted;
    logic [WIDTH-1:0]       w_final;
    logic                   w_final_ovf;

    assign w_invert_b = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
    assign w_a_dig    = r_a[DIGIT-1:0];
    // B is stored already inverted for sub/slt, so one adder serves all arithmetic ops
    assign w_b_dig    = r_b[DIGIT-1:0];
    assign w_sum      = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    assign w_c_msb    = w_sum[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];
    assign w_ovf      = w_c_msb ^ w_sum[DIGIT];
    assign w_cat      = {w_digit, r_res};
    assign w_shifted  = w_cat[WIDTH+DIGIT-1:DIGIT];

    // Per-digit result selection
    always_comb begin
        w_digit = {DIGIT{1'b0}};
        case (r_op)
            OP_ADD, OP_SUB, OP_SLT: w_digit = w_sum[DIGIT-1:0];
            OP_AND:                 w_digit = w_a_dig & w_b_dig;
            OP_OR:                  w_digit = w_a_dig | w_b_dig;
            default:                w_digit = {DIGIT{1'b0}};
        endcase
    end

    // Final result and overflow formed on the last digit
    always_comb begin
        w_final     = {WIDTH{1'b0}};
        w_final_ovf = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_final     = w_shifted;
                w_final_ovf = w_ovf;
            end
            OP_AND, OP_OR: begin
                w_final     = w_shifted;
                w_final_ovf = 1'b0;
            end
            OP_SLT: begin
                w_final     = {{(WIDTH-1){1'b0}}, w_sum[DIGIT-1] ^ w_ovf};
                w_final_ovf = 1'b0;
            end
            default: begin
                w_final     = {WIDTH{1'b0}};
                w_final_ovf = 1'b0;
            end
        endcase
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 3'b000;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_res        <= {WIDTH{1'b0}};
            r_count      <= {CW{1'b0}};
            r_carry      <= 1'b0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            ALUResult    <= {WIDTH{1'b0}};
            Zero         <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_op        <= ALUControl;
                        r_a         <= SrcA;
                        r_b         <= w_invert_b ? ~SrcB : SrcB;
                        r_carry     <= w_invert_b;
                        r_count     <= {CW{1'b0}};
                        start_ready <= 1'b0;
                        r_state     <= S_RUN;
                    end else begin
                        start_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_shifted;
                    r_carry <= w_sum[DIGIT];
                    r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    if (r_count == LAST) begin
                        ALUResult    <= w_final;
                        Zero         <= (w_final == {WIDTH{1'b0}});
                        Overflow     <= w_final_ovf;
                        result_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    start_ready  <= 1'b1;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed cases, backpressure, async reset, random ops
// compared against an arithmetic reference model.
module tb_serial_alu;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NCYC  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;

    int checks = 0;
    int errors = 0;

    serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .ALUControl   (ALUControl),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .ALUResult    (ALUResult),
        .Zero         (Zero),
        .Overflow     (Overflow)
    );

    always #5 clk = ~clk;

    // Reference: returns {overflow, zero, result}
    function automatic logic [33:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            3'b000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b001: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [33:0] e);
        check({tag, " result"},   ALUResult, e[31:0]);
        check({tag, " zero"},     {31'd0, Zero}, {31'd0, e[32]});
        check({tag, " overflow"}, {31'd0, Overflow}, {31'd0, e[33]});
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input string tag);
        logic [33:0] e;
        int          cyc;
        logic        sr_seen;
        e   = ref_model(op, a, b);
        cyc = 0;
        while (!start_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " ready_before"}, {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        ALUControl  = op;
        SrcA        = a;
        SrcB        = b;
        @(posedge clk); #1;
        start_valid = 1'b0;
        SrcA        = $urandom;
        SrcB        = $urandom;
        ALUControl  = 3'($urandom);
        cyc     = 0;
        sr_seen = 1'b0;
        while (!result_valid && cyc < 50) begin
            sr_seen = sr_seen | start_ready;
            @(posedge clk); #1;
            cyc++;
        end
        sr_seen = sr_seen | start_ready;
        check({tag, " latency"}, cyc, NCYC);
        check({tag, " ready_busy"}, {31'd0, sr_seen}, 32'd0);
        check_outs(tag, e);
        sr_seen = 1'b0;
        for (int i = 0; i < stall; i++) begin
            start_valid = ~i[0];
            SrcA        = $urandom;
            SrcB        = $urandom;
            ALUControl  = 3'($urandom);
            @(posedge clk); #1;
            sr_seen = sr_seen | start_ready | ~result_valid;
            if (ALUResult !== e[31:0] || Zero !== e[32] || Overflow !== e[33]) sr_seen = 1'b1;
        end
        start_valid = 1'b0;
        if (stall > 0) check({tag, " stall_stable"}, {31'd0, sr_seen}, 32'd0);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check({tag, " valid_drop"}, {31'd0, result_valid}, 32'd0);
        check({tag, " ready_back"}, {31'd0, start_ready}, 32'd1);
        check({tag, " hold_result"}, ALUResult, e[31:0]);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset        = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        ALUControl   = 3'b000;
        SrcA         = 32'd0;
        SrcB         = 32'd0;
        #12;
        check("rst start_ready",  {31'd0, start_ready}, 32'd1);
        check("rst result_valid", {31'd0, result_valid}, 32'd0);
        check_outs("rst", {1'b0, 1'b0, 32'd0});
        @(posedge clk); #1;
        reset = 1'b0;

        do_op(3'b000, 32'd5, 32'd7, 0, "add5+7");
        do_op(3'b001, 32'd5, 32'd5, 0, "sub5-5");
        do_op(3'b001, 32'h8000_0000, 32'd1, 0, "sub_ovf");
        do_op(3'b000, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
        do_op(3'b101, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
        do_op(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 0, "slt_pos");
        do_op(3'b101, 32'd3, 32'd3, 0, "slt_eq");
        do_op(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, "and");
        do_op(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, "or");
        do_op(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 0, "rsv111");
        do_op(3'b000, 32'hDEAD_BEEF, 32'h0000_1111, 5, "backpressure");
        do_op(3'b000, 32'h7FFF_FFFF, 32'd1, 0, "pre_reset");

        // Abort mid-RUN once three digits have been processed
        start_valid = 1'b1;
        ALUControl  = 3'b000;
        SrcA        = 32'h1234_5678;
        SrcB        = 32'd1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async start_ready",  {31'd0, start_ready}, 32'd1);
        check("async result_valid", {31'd0, result_valid}, 32'd0);
        check_outs("async", {1'b0, 1'b0, 32'd0});
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(3'b000, 32'd1, 32'd1, 0, "after_reset");

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (k % 5 == 0) b = a;
            if (k % 7 == 0) a = 32'h8000_0000;
            do_op(op, a, b, int'($urandom_range(0, 3)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
